// File: rtl/reduction_mux_pipe_pkg.sv
// Shared definitions for the reduction mux pipeline and the downstream adder-tree stage.
package reduction_mux_pipe_pkg;

  // Elastic buffer occupancy states
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Edge tag width per word
  localparam int TAG_W = 2;

  // LSB position of slice idx in a flat vector of w-bit slices
  function automatic int lane_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/reduction_lane_sel.sv
// Single output lane: picks one input word and its tag, flags out-of-range selects.
import reduction_mux_pipe_pkg::*;

module reduction_lane_sel #(
  parameter int DW_DATA = 8,
  parameter int NUM_IN  = 4,
  parameter int SEL_IN  = 2
) (
  input  logic [DW_DATA*NUM_IN-1:0] i_data,
  input  logic [TAG_W*NUM_IN-1:0]   i_tag,
  input  logic [SEL_IN-1:0]         i_sel,
  output logic [DW_DATA-1:0]        o_data,
  output logic [TAG_W-1:0]          o_tag,
  output logic                      o_err
);

  // Scan every legal index so an out-of-range select never indexes past the vector;
  // no match leaves data/tag at zero and raises the error flag.
  always_comb begin
    o_data = '0;
    o_tag  = '0;
    o_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (32'(i_sel) == i) begin
        o_data = i_data[lane_lsb(i, DW_DATA) +: DW_DATA];
        o_tag  = i_tag[lane_lsb(i, TAG_W) +: TAG_W];
        o_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reduction_mux_pipe.sv
// Pipelined reduction mux: NUM_OUT lane selects into a 2-entry elastic buffer
// (main register drives the outputs, skid register absorbs one extra beat).
//
//  state    | meaning
//  ---------+-------------------------------------------
//  ST_EMPTY | no beat held, outputs invalid
//  ST_ONE   | main holds a beat, skid free
//  ST_FULL  | main and skid hold beats, input stalled
import reduction_mux_pipe_pkg::*;

module reduction_mux_pipe #(
  parameter int DW_DATA = 8,
  parameter int NUM_IN  = 4,
  parameter int SEL_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW_DATA*NUM_IN-1:0]  in,
  input  logic [TAG_W*NUM_IN-1:0]    edge_tag_in,
  input  logic [SEL_IN*NUM_OUT-1:0]  sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW_DATA*NUM_OUT-1:0] out,
  output logic [TAG_W*NUM_OUT-1:0]   edge_tag_out,
  output logic [NUM_OUT-1:0]         sel_err,
  output logic                       err_sticky,
  input  logic                       err_clr,
  output logic [CNT_W-1:0]           beat_cnt,
  input  logic                       cnt_clr
);

  localparam int DATA_W = DW_DATA * NUM_OUT;
  localparam int TAGS_W = TAG_W * NUM_OUT;

  buf_state_e r_state;
  buf_state_e w_state_nxt;

  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [TAGS_W-1:0] r_main_tag;
  logic [NUM_OUT-1:0] r_main_err;
  logic [DATA_W-1:0] r_skid_data;
  logic [TAGS_W-1:0] r_skid_tag;
  logic [NUM_OUT-1:0] r_skid_err;
  logic              r_err_sticky;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic [DATA_W-1:0]  w_lane_data;
  logic [TAGS_W-1:0]  w_lane_tag;
  logic [NUM_OUT-1:0] w_lane_err;
  logic w_out_valid;
  logic w_accept;
  logic w_pop;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    reduction_lane_sel #(
      .DW_DATA (DW_DATA),
      .NUM_IN  (NUM_IN),
      .SEL_IN  (SEL_IN)
    ) u_lane (
      .i_data (in),
      .i_tag  (edge_tag_in),
      .i_sel  (sel[k*SEL_IN +: SEL_IN]),
      .o_data (w_lane_data[k*DW_DATA +: DW_DATA]),
      .o_tag  (w_lane_tag[k*TAG_W +: TAG_W]),
      .o_err  (w_lane_err[k])
    );
  end

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = in_valid && r_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  // Next-state and buffer load controls; FULL never sees an accept since in_ready is low there
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = ST_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          w_ld_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nxt    = ST_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register and registered ready, taken from next-state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Main register: loads a fresh beat or takes the skid beat; otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_main_tag  <= '0;
      r_main_err  <= '0;
    end else if (w_ld_main_in) begin
      r_main_data <= w_lane_data;
      r_main_tag  <= w_lane_tag;
      r_main_err  <= w_lane_err;
    end else if (w_ld_main_skid) begin
      r_main_data <= r_skid_data;
      r_main_tag  <= r_skid_tag;
      r_main_err  <= r_skid_err;
    end
  end

  // Skid register: captures the beat accepted while main is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_data <= '0;
      r_skid_tag  <= '0;
      r_skid_err  <= '0;
    end else if (w_ld_skid) begin
      r_skid_data <= w_lane_data;
      r_skid_tag  <= w_lane_tag;
      r_skid_err  <= w_lane_err;
    end
  end

  // Sticky error: a setting accept wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (w_accept && (|w_lane_err)) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  // Output handshake counter, wraps naturally; clear wins over a same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (cnt_clr) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = w_out_valid;
  assign out          = r_main_data;
  assign edge_tag_out = r_main_tag;
  assign sel_err      = r_main_err;
  assign err_sticky   = r_err_sticky;
  assign beat_cnt     = r_beat_cnt;

endmodule

// File: tb/tb_reduction_mux_pipe.sv
// Bench for reduction_mux_pipe: a default-parameter instance plus a NUM_IN=3 / CNT_W=4 instance.
module tb_reduction_mux_pipe;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  tag;
    logic [1:0]  err;
  } beat_t;

  localparam int NIN_A = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [31:0] in_d = '0;
  logic [7:0]  tag_in = '0;
  logic [3:0]  sel_in = '0;
  logic [15:0] out_d;
  logic [3:0]  tag_out;
  logic [1:0]  sel_err;
  logic        err_sticky, err_clr = 0, cnt_clr = 0;
  logic [15:0] beat_cnt;

  // NUM_IN=3, CNT_W=4 instance
  logic        in_valid3 = 0, in_ready3, out_valid3, out_ready3 = 1;
  logic [23:0] in_d3 = '0;
  logic [5:0]  tag_in3 = '0;
  logic [3:0]  sel_in3 = '0;
  logic [15:0] out_d3;
  logic [3:0]  tag_out3;
  logic [1:0]  sel_err3;
  logic        err_sticky3, err_clr3 = 0, cnt_clr3 = 0;
  logic [3:0]  beat_cnt3;

  int n_cmp = 0;
  int n_fail = 0;

  reduction_mux_pipe u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_d), .edge_tag_in(tag_in), .sel(sel_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_d), .edge_tag_out(tag_out),
    .sel_err(sel_err), .err_sticky(err_sticky), .err_clr(err_clr),
    .beat_cnt(beat_cnt), .cnt_clr(cnt_clr)
  );

  reduction_mux_pipe #(.DW_DATA(8), .NUM_IN(3), .SEL_IN(2), .NUM_OUT(2), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in(in_d3), .edge_tag_in(tag_in3), .sel(sel_in3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out(out_d3), .edge_tag_out(tag_out3),
    .sel_err(sel_err3), .err_sticky(err_sticky3), .err_clr(err_clr3),
    .beat_cnt(beat_cnt3), .cnt_clr(cnt_clr3)
  );

  // Reference: lane k takes word sel_k and its tag when in range, else zeros and an error bit
  function automatic beat_t ref_beat(input logic [31:0] d, input logic [7:0] t, input logic [3:0] s);
    beat_t r;
    int sk;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      sk = int'(s[2*k +: 2]);
      if (sk < NIN_A) begin
        r.data[8*k +: 8] = d[8*sk +: 8];
        r.tag[2*k +: 2]  = t[2*sk +: 2];
      end else begin
        r.err[k] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_d, tag_out, sel_err} !== 22'd0) begin n_fail++; $display("FAIL reset_outputs got %h/%b/%b want 0", out_d, tag_out, sel_err); end
    n_cmp++; if (err_sticky !== 1'b0 || beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_status got %b/%0d want 0/0", err_sticky, beat_cnt); end
    n_cmp++; if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1 || beat_cnt3 !== 4'd0) begin n_fail++; $display("FAIL reset_dut3 got v%b r%b c%0d want v0 r1 c0", out_valid3, in_ready3, beat_cnt3); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    in_d = 32'h44332211; tag_in = 8'b11_10_01_00; sel_in = {2'd3, 2'd0};
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_cmp++; if (out_d !== 16'h4411 || tag_out !== 4'b1100 || sel_err !== 2'b00) begin n_fail++; $display("FAIL basic_data got %h/%b/%b want 4411/1100/00", out_d, tag_out, sel_err); end
    tick();
    n_cmp++; if (beat_cnt !== 16'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_cnt got %0d/v%b want 1/v0", beat_cnt, out_valid); end
  endtask

  task automatic test_sel_err();
    in_d3 = 24'h332211; tag_in3 = 6'b10_01_00; sel_in3 = {2'd3, 2'd2};
    in_valid3 = 1; out_ready3 = 1;
    tick();
    in_valid3 = 0;
    n_cmp++; if (out_d3 !== 16'h0033 || tag_out3 !== 4'b0010) begin n_fail++; $display("FAIL selerr_data got %h/%b want 0033/0010", out_d3, tag_out3); end
    n_cmp++; if (sel_err3 !== 2'b10 || err_sticky3 !== 1'b1) begin n_fail++; $display("FAIL selerr_flags got %b/%b want 10/1", sel_err3, err_sticky3); end
    err_clr3 = 1;
    tick();
    err_clr3 = 0;
    n_cmp++; if (err_sticky3 !== 1'b0) begin n_fail++; $display("FAIL selerr_clear got %b want 0", err_sticky3); end
    sel_in3 = {2'd0, 2'd3}; in_valid3 = 1; err_clr3 = 1;
    tick();
    in_valid3 = 0; err_clr3 = 0;
    n_cmp++; if (err_sticky3 !== 1'b1 || sel_err3 !== 2'b01 || out_d3 !== 16'h1100) begin n_fail++; $display("FAIL selerr_setwins got %b/%b/%h want 1/01/1100", err_sticky3, sel_err3, out_d3); end
    tick();
  endtask

  task automatic test_backpressure();
    beat_t ea, eb;
    ea = ref_beat(32'hA1B2C3D4, 8'b00_01_10_11, 4'b01_10);
    eb = ref_beat(32'h55667788, 8'b11_00_11_00, 4'b11_11);
    cnt_clr = 1; tick(); cnt_clr = 0;
    out_ready = 0; in_valid = 1;
    in_d = 32'hA1B2C3D4; tag_in = 8'b00_01_10_11; sel_in = 4'b01_10;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || {out_d, tag_out, sel_err} !== ea) begin n_fail++; $display("FAIL bp_first got r%b %h want r1 %h", in_ready, {out_d, tag_out, sel_err}, ea); end
    in_d = 32'h55667788; tag_in = 8'b11_00_11_00; sel_in = 4'b11_11;
    tick();
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full got r%b v%b want r0 v1", in_ready, out_valid); end
    in_d = 32'hDEADBEEF; sel_in = 4'b00_00;
    tick();
    n_cmp++; if (in_ready !== 1'b0 || {out_d, tag_out, sel_err} !== ea) begin n_fail++; $display("FAIL bp_hold got r%b %h want r0 %h", in_ready, {out_d, tag_out, sel_err}, ea); end
    in_valid = 0; out_ready = 1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || {out_d, tag_out, sel_err} !== eb) begin n_fail++; $display("FAIL bp_drain2 got v%b r%b %h want v1 r1 %h", out_valid, in_ready, {out_d, tag_out, sel_err}, eb); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || beat_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_empty got v%b c%0d want v0 c2", out_valid, beat_cnt); end
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t exp;
    int accepted = 0;
    int pops = 0;
    int cyc = 0;
    localparam int LIMIT = 20000;
    cnt_clr = 1; in_valid = 0; out_ready = 0; tick(); cnt_clr = 0;
    while ((accepted < 1000 || q.size() > 0) && cyc < LIMIT) begin
      if (accepted < 1000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 0;
        out_ready = 1;
      end
      in_d = $urandom; tag_in = 8'($urandom); sel_in = 4'($urandom);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        n_fail++; $display("FAIL rand_flags cyc %0d got v%b r%b want occupancy %0d", cyc, out_valid, in_ready, q.size());
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp = q.pop_front();
        pops++;
        n_cmp++;
        if ({out_d, tag_out, sel_err} !== exp) begin
          n_fail++; $display("FAIL rand_beat %0d got %h want %h", pops, {out_d, tag_out, sel_err}, exp);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_beat(in_d, tag_in, sel_in));
        accepted++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    n_cmp++; if (cyc >= LIMIT) begin n_fail++; $display("FAIL rand_timeout got %0d accepted want 1000 drained", accepted); end
    n_cmp++; if (beat_cnt !== 16'(pops)) begin n_fail++; $display("FAIL rand_cnt got %0d want %0d", beat_cnt, pops); end
  endtask

  task automatic test_wrap();
    cnt_clr3 = 1; in_valid3 = 0; tick(); cnt_clr3 = 0;
    in_d3 = 24'h0A0B0C; tag_in3 = '0; sel_in3 = 4'b00_01; out_ready3 = 1;
    in_valid3 = 1;
    repeat (17) tick();
    in_valid3 = 0;
    tick();
    n_cmp++; if (beat_cnt3 !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt got %0d want 1", beat_cnt3); end
    in_valid3 = 1;
    tick();
    in_valid3 = 0; cnt_clr3 = 1;
    tick();
    cnt_clr3 = 0;
    n_cmp++; if (beat_cnt3 !== 4'd0 || out_valid3 !== 1'b0) begin n_fail++; $display("FAIL wrap_clr_pop got c%0d v%b want c0 v0", beat_cnt3, out_valid3); end
  endtask

  task automatic test_reset_full();
    beat_t ed;
    out_ready = 0; in_valid = 1;
    in_d = 32'h12345678; sel_in = 4'b00_01;
    repeat (2) tick();
    in_valid = 0;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstfull_pre got r%b v%b want r0 v1", in_ready, out_valid); end
    #1 rst = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_d !== 16'd0 || beat_cnt !== 16'd0) begin n_fail++; $display("FAIL rstfull_async got v%b r%b %h c%0d want v0 r1 0 c0", out_valid, in_ready, out_d, beat_cnt); end
    #1 rst = 0;
    tick();
    in_d = 32'hCAFEF00D; tag_in = 8'b01_11_00_10; sel_in = 4'b10_11;
    ed = ref_beat(in_d, tag_in, sel_in);
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || {out_d, tag_out, sel_err} !== ed) begin n_fail++; $display("FAIL rstfull_first got v%b %h want v1 %h", out_valid, {out_d, tag_out, sel_err}, ed); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || beat_cnt !== 16'd1) begin n_fail++; $display("FAIL rstfull_drain got v%b c%0d want v0 c1", out_valid, beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_err();
    test_backpressure();
    test_random();
    test_wrap();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
